// File: rtl/stream_rr_spill_arbiter_if.sv
// rtl/stream_rr_spill_arbiter_if.sv - handshake bundle between requesters, arbiter and downstream sink
//
// master: the environment side (drives requests and downstream ready)
// slave : the arbiter side (drives per-requester ready and the output stream)
//
// inp_valid_i  NumInp      per-requester valid
// inp_ready_o  NumInp      per-requester ready, one-hot or zero
// inp_data_i   NumInp x T  per-requester payload
// oup_valid_o  1           output valid
// oup_ready_i  1           downstream ready
// oup_data_o   T           payload of the oldest buffered item
// oup_idx_o    IdxWidth    requester index of oup_data_o

interface stream_rr_spill_arbiter_if #(
    parameter int  NumInp   = 4,
    parameter type T        = logic,
    parameter int  IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
);
    logic [NumInp-1:0]   inp_valid_i;
    logic [NumInp-1:0]   inp_ready_o;
    T                    inp_data_i [NumInp];
    logic                oup_valid_o;
    logic                oup_ready_i;
    T                    oup_data_o;
    logic [IdxWidth-1:0] oup_idx_o;

    modport master (
        output inp_valid_i, inp_data_i, oup_ready_i,
        input  inp_ready_o, oup_valid_o, oup_data_o, oup_idx_o
    );

    modport slave (
        input  inp_valid_i, inp_data_i, oup_ready_i,
        output inp_ready_o, oup_valid_o, oup_data_o, oup_idx_o
    );
endinterface

// File: rtl/stream_rr_spill_arbiter.sv
// rtl/stream_rr_spill_arbiter.sv - round-robin stream arbiter feeding a two-entry spill buffer
//
// Shares one downstream stream between NumInp valid/ready requesters. The
// winner of a fair round-robin search is written into a two-entry buffer, so
// the output is driven purely from registers and input readies never depend
// on the downstream ready.
//
// clk_i  rising-edge clock
// rst_i  synchronous, active-high reset
// bus    stream_rr_spill_arbiter_if.slave (requester and output handshakes)

module stream_rr_spill_arbiter #(
    parameter int  NumInp   = 4,
    parameter type T        = logic,
    parameter int  IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    stream_rr_spill_arbiter_if.slave      bus
);

    logic [IdxWidth-1:0] rr_q;
    logic                wr_q;
    logic                rd_q;
    logic [1:0]          cnt_q;
    T                    data_q [2];
    logic [IdxWidth-1:0] idx_q  [2];

    logic                any_valid;
    logic                hi_found;
    logic [IdxWidth-1:0] hi_idx;
    logic [IdxWidth-1:0] lo_idx;
    logic [IdxWidth-1:0] gnt;
    logic [IdxWidth-1:0] rr_next;
    logic [NumInp-1:0]   ready;
    T                    push_data;
    logic                full;
    logic                push;
    logic                pop;

    // Two-pass priority search without a rotator: the lowest valid index at
    // or above rr_q wins; failing that, the lowest valid index overall
    // (which is then necessarily below rr_q).
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NumInp - 1; i >= 0; i--) begin
            if (bus.inp_valid_i[i]) begin
                if (IdxWidth'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IdxWidth'(i);
                end
                lo_idx = IdxWidth'(i);
            end
        end
        any_valid = |bus.inp_valid_i;
        gnt       = hi_found ? hi_idx : lo_idx;
    end

    assign rr_next = (gnt == IdxWidth'(NumInp - 1)) ? '0 : gnt + 1'b1;
    assign full    = (cnt_q == 2'd2);

    // Ready is a function of valids, rr_q, cnt_q and reset only; the
    // downstream ready is deliberately absent so no path crosses the buffer.
    always_comb begin
        ready     = '0;
        push_data = bus.inp_data_i[0];
        for (int i = 0; i < NumInp; i++) begin
            if (gnt == IdxWidth'(i)) begin
                ready[i]  = any_valid && !full && !rst_i;
                push_data = bus.inp_data_i[i];
            end
        end
    end

    assign push = |(bus.inp_valid_i & ready);
    assign pop  = (cnt_q != 2'd0) && bus.oup_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q      <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= 2'd0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            idx_q[0]  <= '0;
            idx_q[1]  <= '0;
        end else begin
            if (push) begin
                data_q[wr_q] <= push_data;
                idx_q[wr_q]  <= gnt;
                wr_q         <= ~wr_q;
                rr_q         <= rr_next;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign bus.inp_ready_o = ready;
    assign bus.oup_valid_o = (cnt_q != 2'd0);
    assign bus.oup_data_o  = data_q[rd_q];
    assign bus.oup_idx_o   = idx_q[rd_q];

endmodule

// File: tb/tb_stream_rr_spill_arbiter.sv
// tb/tb_stream_rr_spill_arbiter.sv - directed self-checking bench for stream_rr_spill_arbiter

module tb_stream_rr_spill_arbiter;

    localparam int NumInp = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    stream_rr_spill_arbiter_if #(.NumInp(NumInp), .T(logic [7:0])) bus ();

    stream_rr_spill_arbiter #(.NumInp(NumInp), .T(logic [7:0])) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] valid, input logic oready);
        bus.inp_valid_i = valid;
        bus.oup_ready_i = oready;
        #1;
    endtask

    logic [7:0] sb_q [$];
    logic [7:0] next_data;
    logic [7:0] oready_pat;
    logic       acc;
    logic       popping;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int i = 0; i < NumInp; i++) bus.inp_data_i[i] = 8'h10 + 8'(i);
        bus.inp_valid_i = '0;
        bus.oup_ready_i = 1'b0;

        // reset held 3 cycles with every requester valid
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 1'b0);
            check_eq("rst_ready", 32'(bus.inp_ready_o), 32'h0);
            tick();
        end
        rst = 1'b0;
        drive(4'b0000, 1'b0);
        check_eq("post_rst_valid", 32'(bus.oup_valid_o), 32'h0);
        check_eq("post_rst_idx", 32'(bus.oup_idx_o), 32'h0);
        check_eq("post_rst_data", 32'(bus.oup_data_o), 32'h0);
        check_eq("post_rst_ready", 32'(bus.inp_ready_o), 32'h0);

        // fair rotation, data = index, downstream always ready
        for (int i = 0; i < NumInp; i++) bus.inp_data_i[i] = 8'(i);
        drive(4'b1111, 1'b1);
        check_eq("rot_first_ready", 32'(bus.inp_ready_o), 32'h1);
        check_eq("rot_first_nvalid", 32'(bus.oup_valid_o), 32'h0);
        tick();
        for (int n = 0; n < 8; n++) begin
            check_eq("rot_valid", 32'(bus.oup_valid_o), 32'h1);
            check_eq("rot_idx", 32'(bus.oup_idx_o), 32'(n % 4));
            check_eq("rot_data", 32'(bus.oup_data_o), 32'(n % 4));
            check_eq("rot_ready", 32'(bus.inp_ready_o), 32'(1 << ((n + 1) % 4)));
            tick();
        end
        drive(4'b0000, 1'b1);
        check_eq("rot_tail_idx", 32'(bus.oup_idx_o), 32'h0);
        tick();
        check_eq("rot_drained", 32'(bus.oup_valid_o), 32'h0);

        // backpressure: inputs 1 and 3, rr now at 1
        bus.inp_data_i[1] = 8'hA1;
        bus.inp_data_i[3] = 8'hB3;
        drive(4'b1010, 1'b0);
        check_eq("bp_ready0", 32'(bus.inp_ready_o), 32'b0010);
        tick();
        check_eq("bp_idx0", 32'(bus.oup_idx_o), 32'h1);
        check_eq("bp_ready1", 32'(bus.inp_ready_o), 32'b1000);
        tick();
        check_eq("bp_full_ready", 32'(bus.inp_ready_o), 32'b0000);
        check_eq("bp_hold_idx", 32'(bus.oup_idx_o), 32'h1);
        tick();
        check_eq("bp_still_full", 32'(bus.inp_ready_o), 32'b0000);
        check_eq("bp_hold_data", 32'(bus.oup_data_o), 32'hA1);
        drive(4'b0000, 1'b1);
        check_eq("bp_drain_idx0", 32'(bus.oup_idx_o), 32'h1);
        tick();
        check_eq("bp_drain_idx1", 32'(bus.oup_idx_o), 32'h3);
        check_eq("bp_drain_data1", 32'(bus.oup_data_o), 32'hB3);
        tick();
        check_eq("bp_empty", 32'(bus.oup_valid_o), 32'h0);

        // sparse requests and wrap: rr at 0, grant 3 then only 2
        drive(4'b1000, 1'b1);
        check_eq("sp_ready3", 32'(bus.inp_ready_o), 32'b1000);
        tick();
        drive(4'b0100, 1'b1);
        check_eq("sp_ready2", 32'(bus.inp_ready_o), 32'b0100);
        tick();
        check_eq("sp_out2", 32'(bus.oup_idx_o), 32'h2);
        drive(4'b1001, 1'b1);
        check_eq("sp_rr3_ready", 32'(bus.inp_ready_o), 32'b1000);
        tick();
        check_eq("sp_out3", 32'(bus.oup_idx_o), 32'h3);
        check_eq("sp_wrap_ready", 32'(bus.inp_ready_o), 32'b0001);
        tick();
        check_eq("sp_out0", 32'(bus.oup_idx_o), 32'h0);
        drive(4'b0000, 1'b1);
        tick();
        check_eq("sp_empty", 32'(bus.oup_valid_o), 32'h0);

        // single requester 2 with toggling downstream ready, scoreboard model
        next_data  = 8'h50;
        oready_pat = 8'b1100_1101;
        for (int c = 0; c < 8; c++) begin
            bus.inp_data_i[2] = next_data;
            drive(4'b0100, oready_pat[c]);
            acc     = (sb_q.size() < 2);
            popping = (sb_q.size() > 0) && oready_pat[c];
            check_eq("pp_ready", 32'(bus.inp_ready_o), acc ? 32'b0100 : 32'b0000);
            check_eq("pp_valid", 32'(bus.oup_valid_o), 32'(sb_q.size() != 0));
            if (popping) begin
                check_eq("pp_data", 32'(bus.oup_data_o), 32'(sb_q[0]));
                void'(sb_q.pop_front());
            end
            if (acc) begin
                sb_q.push_back(next_data);
                next_data = next_data + 8'h1;
            end
            tick();
        end
        drive(4'b0000, 1'b1);
        for (int c = 0; c < 4 && sb_q.size() > 0; c++) begin
            check_eq("pp_drain_valid", 32'(bus.oup_valid_o), 32'h1);
            check_eq("pp_drain_data", 32'(bus.oup_data_o), 32'(sb_q[0]));
            void'(sb_q.pop_front());
            tick();
        end
        check_eq("pp_sb_empty", 32'(sb_q.size()), 32'h0);
        check_eq("pp_out_empty", 32'(bus.oup_valid_o), 32'h0);

        // reset mid-operation: rr at 3, inputs 0 and 1 fill the buffer
        bus.inp_data_i[0] = 8'hE0;
        bus.inp_data_i[1] = 8'hE1;
        drive(4'b0011, 1'b0);
        check_eq("mr_ready0", 32'(bus.inp_ready_o), 32'b0001);
        tick();
        check_eq("mr_ready1", 32'(bus.inp_ready_o), 32'b0010);
        tick();
        check_eq("mr_full", 32'(bus.inp_ready_o), 32'b0000);
        check_eq("mr_head", 32'(bus.oup_data_o), 32'hE0);
        rst = 1'b1;
        drive(4'b0011, 1'b1);
        check_eq("mr_rst_ready", 32'(bus.inp_ready_o), 32'h0);
        tick();
        rst = 1'b0;
        drive(4'b0000, 1'b1);
        check_eq("mr_flushed", 32'(bus.oup_valid_o), 32'h0);
        tick();
        check_eq("mr_still_empty", 32'(bus.oup_valid_o), 32'h0);
        drive(4'b1111, 1'b1);
        check_eq("mr_rr_restart", 32'(bus.inp_ready_o), 32'b0001);
        tick();
        check_eq("mr_first_idx", 32'(bus.oup_idx_o), 32'h0);
        check_eq("mr_first_data", 32'(bus.oup_data_o), 32'hE0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
